// File: rtl/alert_pkg.sv
// Shared widths, over-speed state encoding and default alert thresholds.
// Also used by the piezo driver testbench so both sides agree on the numbers.
package alert_pkg;

  localparam int SPD_W  = 12;
  localparam int BATT_W = 12;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    QUAL   = 2'd1,
    ACTIVE = 2'd2,
    HOLD   = 2'd3
  } ovr_state_t;

  localparam logic [BATT_W-1:0] DEF_BATT_LOW_THRESH = 12'h800;
  localparam logic [BATT_W-1:0] DEF_BATT_HYST       = 12'h040;
  localparam int unsigned       DEF_BATT_FILT       = 8;
  localparam logic [SPD_W-1:0]  DEF_SPD_THRESH      = 12'h600;
  localparam logic [SPD_W-1:0]  DEF_SPD_HYST        = 12'h080;
  localparam int unsigned       DEF_SPD_FILT        = 4;
  localparam logic [23:0]       DEF_OVR_HOLD        = 24'd16_777_215;
  localparam logic [SPD_W-1:0]  DEF_MOVE_THRESH     = 12'h060;

endpackage

// File: rtl/alert_filt_cnt.sv
// Consecutive-sample counter: counts matching samples, clears on a miss, and
// flags the sample that makes the run reach N (the run then restarts from zero).
module alert_filt_cnt #(
  parameter int unsigned N = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_en,
  input  logic i_match,
  input  logic i_clr,
  output logic o_hit
);

  localparam logic [7:0] LAST = 8'(N - 1);

  logic [7:0] r_cnt;

  assign o_hit = i_en & i_match & (r_cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= 8'd0;
    end else if (i_clr || o_hit || (i_en && !i_match)) begin
      r_cnt <= 8'd0;
    end else if (i_en && (r_cnt != 8'hFF)) begin
      r_cnt <= r_cnt + 8'd1;
    end
  end

endmodule

// File: rtl/alert_status_gen.sv
// Qualified moving / over-speed / battery-low flags for the piezo alert driver.
// Build option ALERT_BATT_LATCH_EN: batt_low, once set, holds until rst_n.
module alert_status_gen
  import alert_pkg::*;
#(
  parameter logic [BATT_W-1:0] BATT_LOW_THRESH = DEF_BATT_LOW_THRESH,
  parameter logic [BATT_W-1:0] BATT_HYST       = DEF_BATT_HYST,
  parameter int unsigned       BATT_FILT       = DEF_BATT_FILT,
  parameter logic [SPD_W-1:0]  SPD_THRESH      = DEF_SPD_THRESH,
  parameter logic [SPD_W-1:0]  SPD_HYST        = DEF_SPD_HYST,
  parameter int unsigned       SPD_FILT        = DEF_SPD_FILT,
  parameter logic [23:0]       OVR_HOLD        = DEF_OVR_HOLD,
  parameter logic [SPD_W-1:0]  MOVE_THRESH     = DEF_MOVE_THRESH
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [BATT_W-1:0] batt,
  input  logic              batt_vld,
  input  logic [SPD_W-1:0]  lft_spd,
  input  logic [SPD_W-1:0]  rght_spd,
  input  logic              spd_vld,
  input  logic              rider_on,
  output logic              moving,
  output logic              ovr_spd,
  output logic              batt_low,
  output ovr_state_t        dbg_ovr_state
);

  // Strobes carry no backpressure: every cycle a *_vld is high is one sample.
  localparam logic [SPD_W-1:0]  SPD_REL  = SPD_THRESH - SPD_HYST;
  localparam logic [BATT_W:0]   BATT_REC = {1'b0, BATT_LOW_THRESH} + {1'b0, BATT_HYST};

  logic              r_moving;
  logic              r_ovr;
  logic              r_batt_low;
  ovr_state_t        r_state;
  logic [23:0]       r_htmr;

  logic [SPD_W:0]    w_sum;
  logic [SPD_W-1:0]  w_avg;
  logic [SPD_W-1:0]  w_mag;
  logic              w_over;
  logic              w_under;
  logic              w_move;
  logic              w_spd_en;
  logic              w_spd_hit;
  logic              w_batt_en;
  logic              w_batt_match;
  logic              w_batt_hit;

  assign w_sum = {lft_spd[SPD_W-1], lft_spd} + {rght_spd[SPD_W-1], rght_spd};
  assign w_avg = w_sum[SPD_W:1];

  // -2048 has no positive twin in 12 bits; clamp it to full scale.
  always_comb begin
    if (!w_avg[SPD_W-1]) begin
      w_mag = w_avg;
    end else if (w_avg == 12'h800) begin
      w_mag = 12'h7FF;
    end else begin
      w_mag = -w_avg;
    end
  end

  assign w_over  = w_mag > SPD_THRESH;
  assign w_under = w_mag < SPD_REL;
  assign w_move  = w_mag > MOVE_THRESH;

  // Battery: the same counter runs towards LOW or towards recovery.
  assign w_batt_match = r_batt_low ? ({1'b0, batt} >= BATT_REC) : (batt < BATT_LOW_THRESH);
`ifdef ALERT_BATT_LATCH_EN
  assign w_batt_en = batt_vld & ~r_batt_low;
`else
  assign w_batt_en = batt_vld;
`endif

  alert_filt_cnt #(.N(BATT_FILT)) u_batt_filt (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_en    (w_batt_en),
    .i_match (w_batt_match),
    .i_clr   (1'b0),
    .o_hit   (w_batt_hit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_batt_low <= 1'b0;
    end else if (w_batt_hit) begin
      r_batt_low <= ~r_batt_low;
    end
  end

  assign w_spd_en = spd_vld & ((r_state == IDLE) | (r_state == QUAL));

  alert_filt_cnt #(.N(SPD_FILT)) u_spd_filt (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_en    (w_spd_en),
    .i_match (w_over),
    .i_clr   (1'b0),
    .o_hit   (w_spd_hit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_ovr   <= 1'b0;
      r_htmr  <= 24'd0;
    end else begin
      case (r_state)
        IDLE: begin
          if (spd_vld && w_over) begin
            if (w_spd_hit) begin
              r_state <= ACTIVE;
              r_ovr   <= 1'b1;
            end else begin
              r_state <= QUAL;
            end
          end
        end
        QUAL: begin
          if (spd_vld) begin
            if (!w_over) begin
              r_state <= IDLE;
            end else if (w_spd_hit) begin
              r_state <= ACTIVE;
              r_ovr   <= 1'b1;
            end
          end
        end
        ACTIVE: begin
          if (spd_vld && w_under) begin
            r_state <= HOLD;
            r_htmr  <= 24'd0;
          end
        end
        HOLD: begin
          // A fresh over-speed sample wins over the timer expiring.
          if (spd_vld && w_over) begin
            r_state <= ACTIVE;
          end else if (r_htmr == OVR_HOLD) begin
            r_state <= IDLE;
            r_ovr   <= 1'b0;
          end else begin
            r_htmr <= r_htmr + 24'd1;
          end
        end
        default: begin
          r_state <= IDLE;
          r_ovr   <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_moving <= 1'b0;
    end else if (spd_vld || !rider_on) begin
      r_moving <= rider_on & w_move;
    end
  end

  assign moving        = r_moving;
  assign ovr_spd       = r_ovr;
  assign batt_low      = r_batt_low;
  assign dbg_ovr_state = r_state;

endmodule

// File: tb/tb_alert_status_gen.sv
// Bench for alert_status_gen: vector table, directed multi-cycle sequences,
// then random stimulus scored against a behavioural model.
module tb_alert_status_gen;
  import alert_pkg::*;

  localparam int HOLD_N = 100;
`ifdef ALERT_BATT_LATCH_EN
  localparam logic LATCH = 1'b1;
`else
  localparam logic LATCH = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [11:0] batt = 12'h0;
  logic        batt_vld = 1'b0;
  logic [11:0] lft_spd = 12'h0;
  logic [11:0] rght_spd = 12'h0;
  logic        spd_vld = 1'b0;
  logic        rider_on = 1'b0;
  logic        moving;
  logic        ovr_spd;
  logic        batt_low;
  ovr_state_t  dbg_state;

  int n_checks = 0;
  int n_pass = 0;

  alert_status_gen #(.OVR_HOLD(24'd100)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .batt          (batt),
    .batt_vld      (batt_vld),
    .lft_spd       (lft_spd),
    .rght_spd      (rght_spd),
    .spd_vld       (spd_vld),
    .rider_on      (rider_on),
    .moving        (moving),
    .ovr_spd       (ovr_spd),
    .batt_low      (batt_low),
    .dbg_ovr_state (dbg_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    batt_vld = 1'b0;
    spd_vld  = 1'b0;
    lft_spd  = 12'h0;
    rght_spd = 12'h0;
    batt     = 12'hFFF;
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic spd_pulse(input logic [11:0] l, input logic [11:0] r);
    lft_spd  = l;
    rght_spd = r;
    spd_vld  = 1'b1;
    tick();
    spd_vld  = 1'b0;
  endtask

  task automatic batt_pulse(input logic [11:0] b);
    batt     = b;
    batt_vld = 1'b1;
    tick();
    batt_vld = 1'b0;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [11:0] b;
    logic        bv;
    logic [11:0] l;
    logic [11:0] r;
    logic        sv;
    logic        rider;
    logic [2:0]  exp;   // {moving, ovr_spd, batt_low} after this cycle
  } vec_t;
  vec_t tbl[$];

  task automatic add(input logic [11:0] b, input logic bv, input logic [11:0] l,
                     input logic [11:0] r, input logic sv, input logic rider,
                     input logic [2:0] exp);
    vec_t v;
    v.b = b; v.bv = bv; v.l = l; v.r = r; v.sv = sv; v.rider = rider; v.exp = exp;
    tbl.push_back(v);
  endtask

  // ---------------- behavioural reference model ----------------
  logic [2:0] exp_q[$];
  int  m_brun, m_qrun, m_hold_age;
  bit  m_batt_low, m_ovr, m_moving;

  function automatic int mag_of(input logic [11:0] l, input logic [11:0] r);
    int li, ri, s, a;
    li = $signed(l);
    ri = $signed(r);
    s  = li + ri;
    a  = (s >= 0) ? s / 2 : -((1 - s) / 2);
    if (a < 0) a = -a;
    if (a > 2047) a = 2047;
    return a;
  endfunction

  task automatic model_reset();
    m_brun = 0; m_qrun = 0; m_hold_age = -1;
    m_batt_low = 0; m_ovr = 0; m_moving = 0;
  endtask

  task automatic model_step();
    int  mag;
    bit  qual;
    mag = mag_of(lft_spd, rght_spd);
    if (batt_vld && !(LATCH && m_batt_low)) begin
      qual = m_batt_low ? (int'(batt) >= 'h840) : (int'(batt) < 'h800);
      m_brun = qual ? m_brun + 1 : 0;
      if (m_brun == 8) begin
        m_batt_low = !m_batt_low;
        m_brun = 0;
      end
    end
    if (!m_ovr) begin
      if (spd_vld) begin
        if (mag > 'h600) begin
          m_qrun++;
          if (m_qrun == 4) begin
            m_ovr = 1; m_qrun = 0; m_hold_age = -1;
          end
        end else begin
          m_qrun = 0;
        end
      end
    end else if (m_hold_age < 0) begin
      if (spd_vld && mag < 'h580) m_hold_age = 0;
    end else begin
      if (spd_vld && mag > 'h600) m_hold_age = -1;
      else if (m_hold_age == HOLD_N) begin
        m_ovr = 0; m_hold_age = -1;
      end else m_hold_age++;
    end
    if (spd_vld || !rider_on) m_moving = rider_on && (mag > 'h60);
    exp_q.push_back({m_moving, m_ovr, m_batt_low});
  endtask

  initial begin
    logic [11:0] bases[13];
    logic [11:0] base, bmode;
    logic [2:0]  exp_v;
    logic        bl;
    int          cnt, drops;

    // ---- reset state ----
    do_reset();
    check("reset_flags", {moving, ovr_spd, batt_low}, 3'b000);
    check("reset_state", dbg_state, IDLE);

    // ---- table ----
    bl = LATCH;
    for (int i = 0; i < 7; i++) add(12'h7FF, 1, 0, 0, 0, 1, 3'b000);
    add(12'h800, 1, 0, 0, 0, 1, 3'b000);
    for (int i = 0; i < 4; i++) add(12'h7FF, 1, 0, 0, 0, 1, 3'b000);
    add(12'h000, 0, 0, 0, 0, 1, 3'b000);
    for (int i = 0; i < 3; i++) add(12'h7FF, 1, 0, 0, 0, 1, 3'b000);
    add(12'h7FF, 1, 0, 0, 0, 1, 3'b001);
    for (int i = 0; i < 8; i++) add(12'h83F, 1, 0, 0, 0, 1, 3'b001);
    for (int i = 0; i < 7; i++) add(12'h840, 1, 0, 0, 0, 1, 3'b001);
    add(12'h840, 1, 0, 0, 0, 1, {2'b00, bl});
    add(12'h0, 0, 12'h7FF, 12'h801, 1, 1, {2'b00, bl});
    add(12'h0, 0, 12'h100, 12'h100, 1, 1, {2'b10, bl});
    add(12'h0, 0, 12'h000, 12'h000, 1, 1, {2'b00, bl});
    add(12'h0, 0, 12'h100, 12'h100, 1, 1, {2'b10, bl});
    add(12'h0, 0, 12'h000, 12'h000, 0, 0, {2'b00, bl});
    add(12'h0, 0, 12'h100, 12'h100, 1, 0, {2'b00, bl});
    add(12'h0, 0, 12'h100, 12'h100, 0, 1, {2'b00, bl});
    add(12'h0, 0, 12'hF00, 12'hF00, 1, 1, {2'b10, bl});
    add(12'h0, 0, 12'h030, 12'h090, 1, 1, {2'b00, bl});
    add(12'h0, 0, 12'h032, 12'h091, 1, 1, {2'b10, bl});
    for (int i = 0; i < tbl.size(); i++) begin
      batt = tbl[i].b; batt_vld = tbl[i].bv;
      lft_spd = tbl[i].l; rght_spd = tbl[i].r; spd_vld = tbl[i].sv;
      rider_on = tbl[i].rider;
      tick();
      check($sformatf("vec%0d", i), {moving, ovr_spd, batt_low}, tbl[i].exp);
    end
    batt_vld = 0; spd_vld = 0;

    // ---- qualify, abort, qualify, hold expiry ----
    do_reset();
    rider_on = 1;
    spd_pulse(12'h600, 12'h600);
    check("thresh_equal_no_qual", dbg_state, IDLE);
    for (int i = 0; i < 3; i++) begin
      spd_pulse(12'h610, 12'h610);
      tick();
    end
    check("qual3_ovr", ovr_spd, 1'b0);
    check("qual3_state", dbg_state, QUAL);
    spd_pulse(12'h000, 12'h000);
    check("abort_ovr", ovr_spd, 1'b0);
    check("abort_state", dbg_state, IDLE);
    for (int i = 0; i < 3; i++) spd_pulse(12'h610, 12'h610);
    check("qual_pre_ovr", ovr_spd, 1'b0);
    spd_pulse(12'h610, 12'h610);
    check("qual4_ovr", ovr_spd, 1'b1);
    check("qual4_state", dbg_state, ACTIVE);
    spd_pulse(12'h580, 12'h580);
    check("release_equal_stays", dbg_state, ACTIVE);
    spd_pulse(12'h500, 12'h500);
    check("hold_entry_ovr", ovr_spd, 1'b1);
    check("hold_entry_state", dbg_state, HOLD);
    cnt = 1;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (ovr_spd) cnt++;
      else break;
    end
    check("hold_len", cnt, HOLD_N + 1);
    check("hold_exit_state", dbg_state, IDLE);

    // ---- retrigger at htmr=50 ----
    for (int i = 0; i < 4; i++) spd_pulse(12'h610, 12'h610);
    spd_pulse(12'h57F, 12'h57F);
    check("hold2_state", dbg_state, HOLD);
    drops = 0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (!ovr_spd) drops++;
    end
    spd_pulse(12'h610, 12'h610);
    check("retrig_state", dbg_state, ACTIVE);
    for (int i = 0; i < 200; i++) begin
      if (!ovr_spd) drops++;
      tick();
    end
    check("retrig_no_drop", drops, 0);

    // ---- -2048 saturation ----
    do_reset();
    rider_on = 1;
    for (int i = 0; i < 4; i++) spd_pulse(12'h800, 12'h800);
    check("neg_full_ovr", ovr_spd, 1'b1);
    check("neg_full_moving", moving, 1'b1);

    // ---- reset mid-QUAL ----
    do_reset();
    rider_on = 1;
    for (int i = 0; i < 8; i++) batt_pulse(12'h100);
    spd_pulse(12'h610, 12'h610);
    spd_pulse(12'h610, 12'h610);
    check("preRst_flags", {moving, ovr_spd, batt_low}, 3'b101);
    check("preRst_state", dbg_state, QUAL);
    #2;
    rst_n = 1'b0;
    #1;
    check("midRst_flags", {moving, ovr_spd, batt_low}, 3'b000);
    check("midRst_state", dbg_state, IDLE);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    rider_on = 0;
    tick();
    for (int i = 0; i < 3; i++) spd_pulse(12'h610, 12'h610);
    check("postRst_cnt_cleared", ovr_spd, 1'b0);

    // ---- random against model ----
    bases = '{12'h000, 12'h100, 12'h060, 12'h061, 12'h5A0, 12'h57F, 12'h600,
              12'h601, 12'h610, 12'h700, 12'h800, 12'hF00, 12'hA00};
    do_reset();
    model_reset();
    rider_on = 1;
    base = 12'h610;
    bmode = 12'h7F0;
    exp_q.delete();
    for (int c = 0; c < 4000; c++) begin
      if (c % 150 == 0) base = bases[$urandom_range(0, 12)];
      if (c % 64 == 0) begin
        case ($urandom_range(0, 3))
          0: bmode = 12'h7C0;
          1: bmode = 12'h800;
          2: bmode = 12'h840;
          default: bmode = 12'($urandom_range(0, 4095));
        endcase
      end
      batt     = bmode + 12'($urandom_range(0, 63));
      batt_vld = ($urandom_range(0, 2) == 0);
      spd_vld  = ($urandom_range(0, 3) == 0);
      lft_spd  = base;
      rght_spd = ($urandom_range(0, 15) == 0) ? 12'($urandom_range(0, 4095)) : base;
      if ($urandom_range(0, 99) == 0) rider_on = ~rider_on;
      @(posedge clk);
      model_step();
      #1;
      if (exp_q.size() == 0) begin
        check("rand_queue_empty", 32'd0, 32'd1);
      end else begin
        exp_v = exp_q.pop_front();
        check($sformatf("rand_c%0d", c), {moving, ovr_spd, batt_low}, exp_v);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/alert_status_gen.md
Name: alert_status_gen

Overview:
- Producer of the three status flags consumed by the piezo alert driver: moving, ovr_spd, batt_low.
- Qualifies raw battery ADC samples and wheel-speed samples with consecutive-sample filters, hysteresis and a hold timer.
- Flags are therefore glitch-free, level-stable and safe to gate tone patterns directly.
- Sits between the sensor/control datapath (battery ADC interface, motor speed estimate) and the piezo driver.

Parameters:
- BATT_LOW_THRESH, 12'h800, battery code below which the pack counts as low.
- BATT_HYST, 12'h040, added to BATT_LOW_THRESH to form the recovery level.
- BATT_FILT, 8, consecutive qualifying batt samples required to change batt_low (range 1..255).
- SPD_THRESH, 12'h600, |avg speed| above which a sample counts as over-speed.
- SPD_HYST, 12'h080, subtracted from SPD_THRESH to form the release level.
- SPD_FILT, 4, consecutive over-speed samples required to assert ovr_spd (range 1..255).
- OVR_HOLD, 24'd16_777_215, clk cycles ovr_spd stays high after speed drops below release level.
- MOVE_THRESH, 12'h060, |avg speed| above which the unit counts as moving.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset, asynchronous, active-low.
- batt  in  12  unsigned battery ADC code.
- batt_vld  in  1  one-cycle strobe; batt is valid this cycle.
- lft_spd  in  12  signed left wheel speed.
- rght_spd  in  12  signed right wheel speed.
- spd_vld  in  1  one-cycle strobe; both speeds are valid this cycle.
- rider_on  in  1  rider present; level signal.
- moving  out  1  registered moving flag.
- ovr_spd  out  1  registered over-speed flag.
- batt_low  out  1  registered battery-low flag.

Behaviour:
- Reset: moving=0, ovr_spd=0, batt_low=0, all counters=0, ovr FSM=IDLE.
- All outputs are flops. Latency is one clk from the qualifying strobe edge to the output change.
- Speed arithmetic:
  - avg = (sext13(lft_spd) + sext13(rght_spd)) >>> 1, giving 12 bits.
  - mag = |avg|, saturated so that -2048 yields 2047. Unsigned compares only.
- Battery path (two states, NORM/LOW, encoded by batt_low):
  - On each batt_vld in NORM, batt < BATT_LOW_THRESH increments bcnt; otherwise bcnt clears.
  - When bcnt reaches BATT_FILT: batt_low<=1, bcnt<=0.
  - In LOW, batt >= BATT_LOW_THRESH+BATT_HYST (13-bit sum, no wrap) increments bcnt; otherwise bcnt clears. Reaching BATT_FILT sets batt_low<=0.
  - Samples between the two levels clear bcnt in both states.
- Over-speed FSM, updated only on spd_vld except for the HOLD timer:
  - IDLE: mag > SPD_THRESH → QUAL, scnt=1; if SPD_FILT==1, go straight to ACTIVE.
  - QUAL: mag > SPD_THRESH increments scnt; scnt==SPD_FILT → ACTIVE. Otherwise → IDLE, scnt=0.
  - ACTIVE: ovr_spd=1. mag < SPD_THRESH-SPD_HYST → HOLD, htmr=0.
  - HOLD: ovr_spd=1. htmr increments every clk. mag > SPD_THRESH on spd_vld → ACTIVE. htmr==OVR_HOLD → IDLE, ovr_spd<=0.
  - ovr_spd is high exactly in ACTIVE and HOLD.
- moving:
  - Updated on spd_vld: moving <= rider_on & (mag > MOVE_THRESH).
  - rider_on falling forces moving<=0 on the next clk, independent of spd_vld.
- Simultaneous events: batt_vld and spd_vld in the same cycle are processed independently. Flags may change together; no priority is applied (the piezo driver arbitrates).
- Reset mid-operation clears all state immediately. No flag survives reset.
- Strobes wider than one cycle count as one sample per high cycle. Upstream must pulse them.

Optional Feature:
- Macro: ALERT_BATT_LATCH_EN.
- Defined: once batt_low asserts it stays 1 until rst_n. The recovery path and bcnt in LOW are inert.
- Undefined: hysteretic recovery as described above.

Decomposition:
- Shared package alert_pkg holds:
  - speed/battery width localparams (SPD_W=12, BATT_W=12);
  - ovr_state_t enum {IDLE, QUAL, ACTIVE, HOLD};
  - default threshold constants, shared with the piezo driver testbench.
- One natural sub-module: alert_filt_cnt, a saturating consecutive-sample counter with match/clear inputs and a reached-N output. It is instanced for the battery and speed-qualify paths.

Test Plan:
- Battery low:
  - 8 batt_vld pulses with batt=12'h7FF → batt_low=1 one clk after the 8th.
  - 7 pulses then one 12'h800 → batt_low stays 0.
- Battery recovery:
  - From LOW, 8 pulses of 12'h83F → batt_low stays 1.
  - 8 pulses of 12'h840 → batt_low=0 after the 8th.
  - With ALERT_BATT_LATCH_EN, batt_low stays 1.
- Over-speed qualify: lft=rght=12'h610 for 4 spd_vld → ovr_spd=1. Three pulses then lft=rght=0 → ovr_spd stays 0, FSM returns to IDLE.
- Hold and retrigger:
  - After ACTIVE, speed=12'h500 → ovr_spd holds for OVR_HOLD (set to 100 in bench) cycles, then 0.
  - A 12'h610 sample at htmr=50 → back to ACTIVE, ovr_spd never drops.
- Arithmetic edges:
  - lft=rght=12'h800 (-2048) → mag=2047 → ovr_spd qualifies.
  - lft=12'h7FF, rght=12'h801 → avg=0, moving=0.
- moving/reset:
  - rider_on=1, lft=rght=12'h100 → moving=1.
  - Drop rider_on → moving=0 next clk.
  - Assert rst_n low mid-QUAL → all outputs 0, FSM IDLE.
